// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath.
//   CALC_WIDTH   : operand/result width shared by the entry sequencer and ALU
//   calc_state_e : entry-sequencer phase, also shown on the phase LEDs
//   alu_op_e     : ALU opcode encoding, common to sequencer and ALU
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [2:0] {
    LOAD_X  = 3'd0,
    LOAD_Y  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } calc_state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_NOR = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_ASR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/btn_cond.sv
// Push-button conditioner: synchronizer, debounce filter and rising-edge pulse.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_btn          : raw, bouncy, active-high button
//   o_pulse        : registered one-cycle pulse when the debounced level rises
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_pulse;
  logic                   w_s;
  logic                   w_cnt_done;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_cnt_done = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Synchronizer shift chain for the asynchronous button input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Debounce: the new level must persist for DEBOUNCE_CYCLES consecutive cycles.
  // Any return to the stable level restarts the count, so short glitches vanish.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= w_s & ~r_stable & w_cnt_done;
      if (w_s != r_stable) begin
        if (w_cnt_done) begin
          r_stable <= w_s;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/calc_entry_seq.sv
// Operand/opcode entry sequencer feeding the calculator ALU.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_sw                    : slide switches (operand, or opcode in bits [2:0])
//   i_btn_enter/i_btn_clear : raw push-buttons, debounced internally
//   i_alu_result            : combinational ALU result from o_alu_*
//   o_alu_op/o_alu_x/o_alu_y: registered ALU operands
//   o_display               : value for the display stage
//   o_phase                 : current state encoding for LEDs
//   o_result_valid          : high while the result is shown
module calc_entry_seq
  import calc_pkg::*;
#(
  parameter int WIDTH           = CALC_WIDTH,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sw,
  input  logic             i_btn_enter,
  input  logic             i_btn_clear,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic [2:0]       o_alu_op,
  output logic [WIDTH-1:0] o_alu_x,
  output logic [WIDTH-1:0] o_alu_y,
  output logic [WIDTH-1:0] o_display,
  output logic [2:0]       o_phase,
  output logic             o_result_valid
);

  calc_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, r_y, r_res;
  logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_res_nxt;
  alu_op_e          r_op, w_op_nxt;
  logic             r_valid;
  logic             w_enter, w_clear;
  logic [WIDTH-1:0] w_display;

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_enter (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_enter), .o_pulse(w_enter)
  );

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clear (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_clear), .o_pulse(w_clear)
  );

  // Next-state, data-register updates and display selection.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_display   = i_sw;

    case (r_state)
      LOAD_X:  w_display = i_sw;
      LOAD_Y:  w_display = i_sw;
      LOAD_OP: w_display = {{(WIDTH-3){1'b0}}, i_sw[2:0]};
      EXEC:    w_display = i_sw;
      SHOW:    w_display = r_res;
      default: w_display = i_sw;
    endcase

    // Clear outranks enter in every state, including EXEC (result discarded).
    if (w_clear) begin
      w_state_nxt = LOAD_X;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_op_nxt    = OP_ADD;
      w_res_nxt   = '0;
    end else begin
      case (r_state)
        LOAD_X: begin
          if (w_enter) begin
            w_x_nxt     = i_sw;
            w_state_nxt = LOAD_Y;
          end else begin
            w_state_nxt = LOAD_X;
          end
        end
        LOAD_Y: begin
          if (w_enter) begin
            w_y_nxt     = i_sw;
            w_state_nxt = LOAD_OP;
          end else begin
            w_state_nxt = LOAD_Y;
          end
        end
        LOAD_OP: begin
          if (w_enter) begin
            w_op_nxt    = alu_op_e'(i_sw[2:0]);
            w_state_nxt = EXEC;
          end else begin
            w_state_nxt = LOAD_OP;
          end
        end
        // Single cycle; enter is deliberately ignored here.
        EXEC: begin
          w_res_nxt   = i_alu_result;
          w_state_nxt = SHOW;
        end
        // Chaining: the shown result becomes the next X.
        SHOW: begin
          if (w_enter) begin
            w_x_nxt     = r_res;
            w_state_nxt = LOAD_Y;
          end else begin
            w_state_nxt = SHOW;
          end
        end
        default: w_state_nxt = LOAD_X;
      endcase
    end
  end

  // State and data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LOAD_X;
      r_x     <= '0;
      r_y     <= '0;
      r_op    <= OP_ADD;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_op    <= w_op_nxt;
      r_res   <= w_res_nxt;
      r_valid <= (w_state_nxt == SHOW);
    end
  end

  assign o_alu_x        = r_x;
  assign o_alu_y        = r_y;
  assign o_alu_op       = r_op;
  assign o_phase        = r_state;
  assign o_result_valid = r_valid;
  assign o_display      = w_display;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Directed self-checking bench for calc_entry_seq with a behavioural ALU.
module tb_calc_entry_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [7:0] alu_result;
  logic [2:0] alu_op;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [7:0] display;
  logic [2:0] phase;
  logic       result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  calc_entry_seq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw),
    .i_btn_enter(btn_enter), .i_btn_clear(btn_clear),
    .i_alu_result(alu_result),
    .o_alu_op(alu_op), .o_alu_x(alu_x), .o_alu_y(alu_y),
    .o_display(display), .o_phase(phase), .o_result_valid(result_valid)
  );

  // Behavioural ALU.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'd0: alu_result = alu_x + alu_y;
      3'd1: alu_result = alu_x - alu_y;
      3'd2: alu_result = alu_x & alu_y;
      3'd3: alu_result = ~(alu_x | alu_y);
      3'd4: alu_result = alu_x ^ alu_y;
      3'd5: alu_result = {alu_x[6:0], 1'b0};
      3'd6: alu_result = {1'b0, alu_x[7:1]};
      3'd7: alu_result = {alu_x[7], alu_x[7:1]};
      default: alu_result = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ent, input logic clr, input int hold);
    btn_enter = ent;
    btn_clear = clr;
    repeat (hold) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) tick();
  endtask

  logic valid_seen;

  initial begin
    rst_n = 1'b0; sw = 8'h00; btn_enter = 1'b0; btn_clear = 1'b0;
    #12 rst_n = 1'b1;
    tick(); tick();
    check_eq("init_phase", phase, 32'd0);
    check_eq("init_valid", result_valid, 32'd0);

    // Load an X, then reset mid-cycle: outputs must drop immediately.
    sw = 8'h55;
    press(1'b1, 1'b0, 8);
    check_eq("pre_rst_phase", phase, 32'd1);
    check_eq("pre_rst_x", alu_x, 32'h55);
    sw = 8'h3C;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_phase", phase, 32'd0);
    check_eq("rst_x", alu_x, 32'h00);
    check_eq("rst_valid", result_valid, 32'd0);
    check_eq("rst_display", display, 32'h3C);
    tick();
    rst_n = 1'b1;
    tick();

    // Add 5 + 3.
    sw = 8'h05;
    press(1'b1, 1'b0, 8);
    check_eq("add_x", alu_x, 32'h05);
    check_eq("ldy_phase", phase, 32'd1);
    sw = 8'h03;
    press(1'b1, 1'b0, 8);
    check_eq("add_y", alu_y, 32'h03);
    check_eq("ldop_phase", phase, 32'd2);
    sw = 8'h0F;
    #1;
    check_eq("ldop_display", display, 32'h07);
    sw = 8'h00;
    btn_enter = 1'b1;
    repeat (7) tick();
    check_eq("exec_phase", phase, 32'd3);
    check_eq("exec_valid", result_valid, 32'd0);
    tick();
    check_eq("show_phase", phase, 32'd4);
    check_eq("show_valid", result_valid, 32'd1);
    check_eq("show_display", display, 32'h08);
    btn_enter = 1'b0;
    repeat (12) tick();

    // Chain: result becomes X, then 8 - 10 wraps to 0xFE.
    sw = 8'hAA;
    press(1'b1, 1'b0, 8);
    check_eq("chain_phase", phase, 32'd1);
    check_eq("chain_x", alu_x, 32'h08);
    check_eq("chain_y_kept", alu_y, 32'h03);
    sw = 8'h0A;
    press(1'b1, 1'b0, 8);
    sw = 8'h01;
    press(1'b1, 1'b0, 8);
    check_eq("sub_phase", phase, 32'd4);
    check_eq("sub_op", alu_op, 32'd1);
    check_eq("sub_display", display, 32'hFE);
    check_eq("sub_valid", result_valid, 32'd1);

    // Debounce: 3-cycle glitch ignored; 8-cycle hold yields one pulse at edge 6.
    press(1'b1, 1'b0, 3);
    check_eq("glitch_phase", phase, 32'd4);
    btn_enter = 1'b1;
    repeat (5) tick();
    check_eq("pulse_e5", dut.u_enter.o_pulse, 32'd0);
    tick();
    check_eq("pulse_e6", dut.u_enter.o_pulse, 32'd1);
    tick();
    check_eq("pulse_e7", dut.u_enter.o_pulse, 32'd0);
    check_eq("db_phase", phase, 32'd1);
    check_eq("db_x", alu_x, 32'hFE);
    tick();
    btn_enter = 1'b0;
    repeat (12) tick();
    check_eq("release_phase", phase, 32'd1);

    // Clear beats a simultaneous enter in LOAD_OP.
    sw = 8'h11;
    press(1'b1, 1'b0, 8);
    check_eq("pre_clr_phase", phase, 32'd2);
    sw = 8'h05;
    press(1'b1, 1'b1, 8);
    check_eq("clr_phase", phase, 32'd0);
    check_eq("clr_x", alu_x, 32'h00);
    check_eq("clr_y", alu_y, 32'h00);
    check_eq("clr_op", alu_op, 32'd0);

    // Clear pulse landing in EXEC discards the result.
    sw = 8'h20;
    press(1'b1, 1'b0, 8);
    sw = 8'h30;
    press(1'b1, 1'b0, 8);
    sw = 8'h00;
    valid_seen = 1'b0;
    btn_enter = 1'b1;
    tick();
    valid_seen = valid_seen | result_valid;
    btn_clear = 1'b1;
    repeat (6) begin
      tick();
      valid_seen = valid_seen | result_valid;
    end
    check_eq("clrx_exec_phase", phase, 32'd3);
    tick();
    valid_seen = valid_seen | result_valid;
    check_eq("clrx_phase", phase, 32'd0);
    check_eq("clrx_res", dut.r_res, 32'h00);
    btn_enter = 1'b0;
    tick();
    btn_clear = 1'b0;
    repeat (12) begin
      tick();
      valid_seen = valid_seen | result_valid;
    end
    check_eq("clrx_valid_never", valid_seen, 32'd0);
    check_eq("clrx_x", alu_x, 32'h00);
    check_eq("clrx_end_phase", phase, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_seq.md
Name: calc_entry_seq

Overview:
- Upstream operand/opcode entry sequencer for the 8-bit calculator ALU.
- Collects X, Y and op from the slide switches using two push-buttons (enter, clear), each debounced.
- Drives the ALU inputs from registers and captures the ALU result.
- Presents a display value and phase indicator, and supports chaining: the result becomes the next X.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change; minimum 2.
- SYNC_STAGES, 2, synchronizer flops per button input; minimum 2.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sw  in  WIDTH  raw slide switches (operand value; bits [2:0] = opcode in LOAD_OP)
- i_btn_enter  in  1  raw, bouncy enter button, active-high
- i_btn_clear  in  1  raw, bouncy clear button, active-high
- i_alu_result  in  WIDTH  ALU result (combinational from o_alu_*)
- o_alu_op  out  3  registered opcode to ALU
- o_alu_x  out  WIDTH  registered X to ALU
- o_alu_y  out  WIDTH  registered Y to ALU
- o_display  out  WIDTH  value for the display stage
- o_phase  out  3  current state encoding, for LEDs
- o_result_valid  out  1  high while in SHOW

Behaviour:
- Reset (async assert, sync release): state=LOAD_X. x_reg, y_reg, op_reg and res_reg are all 0. o_result_valid=0. o_phase=LOAD_X. o_display follows i_sw. Button conditioners are cleared with stable=0, cnt=0, pulse=0.
- Button conditioner:
  - SYNC_STAGES-flop synchronizer produces s.
  - When s!=stable, cnt increments. When s==stable, cnt clears.
  - When s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s and cnt<=0.
  - Registered pulse is high for exactly one cycle, the cycle in which stable goes 0->1.
  - Latency: the first raw-high sample occurs at edge 1. The pulse is visible after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - No pulse on release. A glitch shorter than DEBOUNCE_CYCLES gives no pulse.
- FSM states (o_phase): LOAD_X=0, LOAD_Y=1, LOAD_OP=2, EXEC=3, SHOW=4.
  - LOAD_X: display=i_sw. On enter, x_reg<=i_sw and go to LOAD_Y.
  - LOAD_Y: display=i_sw. On enter, y_reg<=i_sw and go to LOAD_OP.
  - LOAD_OP: display={zeros, i_sw[2:0]}. On enter, op_reg<=i_sw[2:0] and go to EXEC.
  - EXEC: lasts exactly one cycle. res_reg<=i_alu_result, then go to SHOW. The ALU inputs are already stable at this point because they come from registers.
  - SHOW: display=res_reg and o_result_valid=1. On enter, x_reg<=res_reg and go to LOAD_Y (chaining). y_reg and op_reg keep their values until overwritten.
- Clear pulse, in any state:
  - Next state is LOAD_X, and all four data registers go to 0.
  - Clear beats a simultaneous enter pulse.
  - Clear during EXEC discards the result.
- Enter pulses arriving in EXEC are ignored. This cannot occur in practice at DEBOUNCE_CYCLES>=2, but is still required.
- o_alu_* always equal x_reg, y_reg and op_reg; they never change in EXEC or SHOW.
- Arithmetic: none here. The result is WIDTH bits as produced by the ALU, with wrap-around inherited from it.
- Undefined states (5-7) return to LOAD_X on the next clock.

Decomposition:
- Package calc_pkg holds:
  - localparam CALC_WIDTH=8.
  - typedef enum logic[2:0] calc_state_e {LOAD_X, LOAD_Y, LOAD_OP, EXEC, SHOW}.
  - typedef enum logic[2:0] alu_op_e {OP_ADD=0, OP_SUB, OP_AND, OP_NOR, OP_XOR, OP_SHL, OP_SHR, OP_ASR}. The ALU will adopt this enum too.
- One sub-module, btn_cond (synchronizer + debounce + rise pulse), parameterised by DEBOUNCE_CYCLES and SYNC_STAGES, instantiated twice.

Test Plan (benches use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, and a behavioural ALU model):
- Reset: assert i_rst_n=0 mid-cycle -> outputs go to 0 immediately, o_phase=0, o_result_valid=0, o_display=i_sw.
- Add: sw=0x05 enter, sw=0x03 enter, sw=0 enter -> EXEC lasts one cycle, then SHOW with o_display=0x08 and o_result_valid=1.
- Chain with wrap: from SHOW 0x08, enter gives o_alu_x=0x08 in LOAD_Y. Then Y=0x0A, op=1 -> result 0xFE.
- Debounce: 3-cycle enter glitch -> no state change. 8-cycle hold -> exactly one transition, with the pulse exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after press. Release produces no transition.
- Clear priority: clear and enter pressed together in LOAD_OP -> LOAD_X with all registers 0, and op_reg not loaded.
- Clear in EXEC: force a clear pulse aligned to EXEC -> next state LOAD_X, res_reg=0, o_result_valid never asserted.
